wm8978_vol_ctrl: RTL

- Runtime volume/mute controller and I2C-write arbiter for the WM8978 codec. It sits between the power-up register configurator and the I2C driver.
- Until the configurator reports init_done, it passes the configurator's exec/data straight through.
- After init_done it owns the driver. It turns vol_up/vol_down/mute_tgl pulses into coalesced 4-write sequences (R52, R53, R54, R55) with a per-write timeout.

---
 rtl/wm8978_vol_ctrl_pkg.sv | 42 ++++
 rtl/wm8978_vol_ctrl_if.sv | 22 ++
 rtl/wm8978_vol_ctrl_vol_sat_step.sv | 24 ++
 rtl/wm8978_vol_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/wm8978_vol_ctrl_pkg.sv
// Shared constants, state encoding and write-word builder for the WM8978
// runtime volume controller.
package wm8978_pkg;

    localparam logic [6:0] REG_LOUT1 = 7'd52;
    localparam logic [6:0] REG_ROUT1 = 7'd53;
    localparam logic [6:0] REG_LOUT2 = 7'd54;
    localparam logic [6:0] REG_ROUT2 = 7'd55;

    localparam int VU   = 8;
    localparam int ZC   = 7;
    localparam int MUTE = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Word layout is {addr[6:0], VU, ZC, MUTE, vol[5:0]}; VU is set on the
    // right-channel write so both channels latch together.
    function automatic logic [15:0] vol_word(input logic [1:0] idx,
                                             input logic       m,
                                             input logic [5:0] hp,
                                             input logic [5:0] spk);
        logic [15:0] w;
        w = '0;
        unique case (idx)
            2'd0:    w[15:9] = REG_LOUT1;
            2'd1:    w[15:9] = REG_ROUT1;
            2'd2:    w[15:9] = REG_LOUT2;
            default: w[15:9] = REG_ROUT2;
        endcase
        w[VU]   = idx[0];
        w[ZC]   = 1'b1;
        w[MUTE] = m;
        w[5:0]  = idx[1] ? spk : hp;
        return w;
    endfunction

endpackage

// File: rtl/wm8978_vol_ctrl_if.sv
// Configurator and I2C-driver side signals of the volume controller.
// Handshake: i2c_exec is a one-cycle request with i2c_data valid in that
// cycle and held until the next request; i2c_done is a one-cycle completion
// pulse from the driver; at most one write is outstanding at a time.
interface wm8978_vol_ctrl_if;
    logic        init_exec;
    logic [15:0] init_data;
    logic        init_done;
    logic        i2c_done;
    logic        i2c_exec;
    logic [15:0] i2c_data;

    modport master (
        input  init_exec, init_data, init_done, i2c_done,
        output i2c_exec, i2c_data
    );

    modport slave (
        output init_exec, init_data, init_done, i2c_done,
        input  i2c_exec, i2c_data
    );
endinterface

// File: rtl/wm8978_vol_ctrl_vol_sat_step.sv
// 6-bit volume register stepping up/down by STEP with saturation at 0 and 63.
// Simultaneous up and down cancel out.
module vol_sat_step #(
    parameter logic [5:0] INIT = 6'd30,
    parameter logic [5:0] STEP = 6'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up,
    input  logic       down,
    output logic [5:0] value
);
    localparam logic [5:0] MAX_VOL = 6'd63;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= INIT;
        end else if (up && !down) begin
            value <= (value > MAX_VOL - STEP) ? MAX_VOL : value + STEP;
        end else if (down && !up) begin
            value <= (value < STEP) ? 6'd0 : value - STEP;
        end
    end
endmodule

// File: rtl/wm8978_vol_ctrl.sv
// WM8978 runtime volume/mute controller: passes configurator writes through
// until init_done, then owns the I2C driver and emits R52..R55 sequences.
module wm8978_vol_ctrl
    import wm8978_pkg::*;
#(
    parameter logic [5:0]  PHONE_VOL_INIT = 6'd30,
    parameter logic [5:0]  SPEAK_VOL_INIT = 6'd45,
    parameter logic [5:0]  VOL_STEP       = 6'd3,
    parameter logic [15:0] TIMEOUT_CYC    = 16'd2000
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    wm8978_vol_ctrl_if.master         bus,
    input  logic                      vol_up,
    input  logic                      vol_down,
    input  logic                      mute_tgl,
    output logic                      busy,
    output logic [5:0]                hp_vol,
    output logic [5:0]                spk_vol,
    output logic                      muted,
    output logic                      err,
    output state_t                    fsm_state
);
    state_t      state_q, state_d;
    logic        pending;
    logic [1:0]  idx;
    logic [15:0] timer;
    logic        exec_q;
    logic [15:0] data_q;
    logic [5:0]  sh_hp, sh_spk;
    logic        sh_m;
    logic        any_evt;
    logic        timed_out;

    // Up together with down is a no-op and must not schedule a sequence.
    assign any_evt   = (vol_up ^ vol_down) | mute_tgl;
    assign timed_out = (timer == TIMEOUT_CYC - 16'd1);
    assign fsm_state = state_q;

    vol_sat_step #(.INIT(PHONE_VOL_INIT), .STEP(VOL_STEP)) u_hp (
        .clk(clk), .rst_n(sys_rst), .up(vol_up), .down(vol_down), .value(hp_vol)
    );

    vol_sat_step #(.INIT(SPEAK_VOL_INIT), .STEP(VOL_STEP)) u_spk (
        .clk(clk), .rst_n(sys_rst), .up(vol_up), .down(vol_down), .value(spk_vol)
    );

    // A new event in the LOAD cycle wins over the clear, so it is not lost.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pending <= 1'b0;
            muted   <= 1'b0;
        end else begin
            if (mute_tgl)
                muted <= ~muted;
            if (any_evt)
                pending <= 1'b1;
            else if (state_q == LOAD)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.init_done && pending) state_d = LOAD;
            LOAD:  state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.i2c_done)
                    state_d = (idx == 2'd3) ? IDLE : ISSUE;
                else if (timed_out)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write word is prepared on the edge entering ISSUE so it is valid with exec.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            idx    <= 2'd0;
            timer  <= 16'd0;
            busy   <= 1'b0;
            err    <= 1'b0;
            exec_q <= 1'b0;
            data_q <= 16'd0;
            sh_hp  <= 6'd0;
            sh_spk <= 6'd0;
            sh_m   <= 1'b0;
        end else begin
            exec_q <= (state_d == ISSUE);
            unique case (state_q)
                LOAD: begin
                    sh_hp  <= hp_vol;
                    sh_spk <= spk_vol;
                    sh_m   <= muted;
                    idx    <= 2'd0;
                    busy   <= 1'b1;
                    data_q <= vol_word(2'd0, muted, hp_vol, spk_vol);
                end
                ISSUE: timer <= 16'd0;
                WAIT: begin
                    if (bus.i2c_done) begin
                        if (idx == 2'd3) begin
                            busy <= 1'b0;
                        end else begin
                            idx    <= idx + 2'd1;
                            data_q <= vol_word(idx + 2'd1, sh_m, sh_hp, sh_spk);
                        end
                    end else if (timed_out) begin
                        err  <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.i2c_exec = bus.init_done ? exec_q : bus.init_exec;
    assign bus.i2c_data = bus.init_done ? data_q : bus.init_data;

endmodule
